// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
// Build option: MC_PERF_COUNTERS_EN enables the performance counters in multicycle_control.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAddr  = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StRExec    = 4'd6,
        StRWb      = 4'd7,
        StBranch   = 4'd8,
        StJump     = 4'd9,
        StIExec    = 4'd10,
        StIWb      = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_IMM   = 2'b11;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that block on the memory ready handshake.
    function automatic logic is_wait_state(input state_e s);
        return (s == StFetch) || (s == StMemRead) || (s == StMemWrite);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multicycle sequencer (master) and the datapath (slave).
interface multicycle_control_if;
    logic [5:0]  op;
    logic        zero;
    logic        mem_ready;
    logic        pc_write;
    logic        pc_write_cond;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic [1:0]  pc_source;
    logic [3:0]  state;
    logic        illegal_op;
    logic        mem_timeout;
    logic [31:0] cycle_count;
    logic [31:0] instr_count;

    modport master (
        input  op, zero, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
               state, illegal_op, mem_timeout, cycle_count, instr_count
    );

    modport slave (
        output op, zero, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
               state, illegal_op, mem_timeout, cycle_count, instr_count
    );
endinterface

// File: rtl/mc_op_decode.sv
// Opcode decoder: selects the state following DECODE and flags unsupported opcodes.
module mc_op_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] i_op,
    output state_e     o_next_state,
    output logic       o_illegal
);

    always_comb begin
        o_next_state = StFetch;
        o_illegal    = 1'b0;
        case (i_op)
            OP_RTYPE:                         o_next_state = StRExec;
            OP_LW, OP_SW:                     o_next_state = StMemAddr;
            OP_BEQ:                           o_next_state = StBranch;
            OP_J:                             o_next_state = StJump;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: o_next_state = StIExec;
            default:                          o_illegal    = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencer for the multicycle MIPS core with bounded memory waits.
// Build option: MC_PERF_COUNTERS_EN adds the cycle and retired-instruction counters.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                  clk,
    input logic                  rst,
    multicycle_control_if.master bus
);

    localparam logic [15:0] W_WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e      r_state;
    state_e      w_next;
    state_e      w_dec_next;
    logic        w_dec_illegal;
    logic [15:0] r_wait;
    logic        w_stall;
    logic        w_timeout;

    mc_op_decode u_op_decode (
        .i_op        (bus.op),
        .o_next_state(w_dec_next),
        .o_illegal   (w_dec_illegal)
    );

    assign w_stall   = is_wait_state(r_state) && !bus.mem_ready;
    assign w_timeout = w_stall && (r_wait == W_WAIT_LAST);

    always_comb begin
        w_next = StFetch;
        case (r_state)
            StFetch:    w_next = bus.mem_ready ? StDecode : StFetch;
            StDecode:   w_next = w_dec_next;
            StMemAddr:  w_next = (bus.op == OP_SW) ? StMemWrite : StMemRead;
            StMemRead:  w_next = bus.mem_ready ? StMemWb : StMemRead;
            StMemWrite: w_next = bus.mem_ready ? StFetch : StMemWrite;
            StRExec:    w_next = StRWb;
            StIExec:    w_next = StIWb;
            default:    w_next = StFetch;
        endcase
        if (w_timeout) w_next = StFetch;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StFetch;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            // A timed-out FETCH stays in FETCH but still starts a fresh wait window.
            if (w_next != r_state || w_timeout) r_wait <= '0;
            else if (w_stall)                   r_wait <= r_wait + 16'd1;
        end
    end

    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = SRCB_REG;
        bus.alu_op        = ALU_ADD;
        bus.pc_source     = PCSRC_ALU;
        bus.state         = 4'd0;
        bus.illegal_op    = 1'b0;
        bus.mem_timeout   = 1'b0;
        if (!rst) begin
            bus.state       = r_state;
            bus.illegal_op  = (r_state == StDecode) && w_dec_illegal;
            bus.mem_timeout = w_timeout;
            case (r_state)
                StFetch: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = SRCB_FOUR;
                    bus.ir_write  = bus.mem_ready;
                    bus.pc_write  = bus.mem_ready;
                end
                StDecode: bus.alu_src_b = SRCB_IMM_SH2;
                StMemAddr: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SRCB_IMM;
                end
                StMemRead: begin
                    bus.mem_read = 1'b1;
                    bus.i_or_d   = 1'b1;
                end
                StMemWb: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                end
                StMemWrite: begin
                    bus.mem_write = 1'b1;
                    bus.i_or_d    = 1'b1;
                end
                StRExec: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = ALU_FUNCT;
                end
                StRWb: begin
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = 1'b1;
                end
                StBranch: begin
                    bus.alu_src_a     = 1'b1;
                    bus.alu_op        = ALU_SUB;
                    bus.pc_write_cond = 1'b1;
                    bus.pc_source     = PCSRC_ALUOUT;
                end
                StJump: begin
                    bus.pc_write  = 1'b1;
                    bus.pc_source = PCSRC_JUMP;
                end
                StIExec: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SRCB_IMM;
                    bus.alu_op    = ALU_IMM;
                end
                StIWb: bus.reg_write = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef MC_PERF_COUNTERS_EN
    logic [31:0] r_cycle;
    logic [31:0] r_instr;
    logic        w_retire;

    // Only normal completions retire; illegal-op and timeout returns do not.
    assign w_retire = !w_timeout && (w_next == StFetch) &&
                      (r_state inside {StMemWb, StMemWrite, StRWb, StBranch, StJump, StIWb});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle <= '0;
            r_instr <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_retire) r_instr <= r_instr + 32'd1;
        end
    end

    assign bus.cycle_count = rst ? 32'd0 : r_cycle;
    assign bus.instr_count = rst ? 32'd0 : r_instr;
`else
    assign bus.cycle_count = 32'd0;
    assign bus.instr_count = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: a per-cycle schedule built from instruction-level
// descriptions (opcode, stall counts) is replayed and every output compared each cycle.
module tb_multicycle_control;

    localparam int unsigned TO = 4;
`ifdef MC_PERF_COUNTERS_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_if bus ();

    multicycle_control #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        bit         r;
        logic [5:0] op;
        bit         rdy;
        bit         z;
        int         st;
        bit         ill;
        bit         to;
        bit         ret;
    } ent_t;

    ent_t        sched[$];
    logic [5:0]  cur_op   = 6'd0;
    bit          cur_zero = 1'b0;
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_cycle  = 32'd0;
    logic [31:0] m_instr  = 32'd0;
    int          ill_seen = 0;
    int          to_seen  = 0;

    task automatic check(input string name, input int cyc, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    // Control word a state must present: {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
    // ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}.
    function automatic logic [15:0] exp_ctl(input int st, input bit rdy);
        logic pcw, pwc, iod, mr, mw, irw, rd, m2r, rw, sa;
        logic [1:0] sb, ao, ps;
        {pcw, pwc, iod, mr, mw, irw, rd, m2r, rw, sa} = '0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (st)
            0:  begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
            1:  sb = 2'b11;
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mr = 1; iod = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iod = 1; end
            6:  begin sa = 1; ao = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
            9:  begin pcw = 1; ps = 2'b10; end
            10: begin sa = 1; sb = 2'b10; ao = 2'b11; end
            11: rw = 1;
            default: ;
        endcase
        return {pcw, pwc, iod, mr, mw, irw, rd, m2r, rw, sa, sb, ao, ps};
    endfunction

    task automatic push_e(input bit r, input int st, input bit rdy, input bit ill, input bit to,
                          input bit ret);
        ent_t e;
        e.r = r; e.op = cur_op; e.rdy = rdy; e.z = cur_zero;
        e.st = st; e.ill = ill; e.to = to; e.ret = ret;
        sched.push_back(e);
    endtask

    // A memory wait: `stalls` not-ready cycles then a ready one, cut short by the timeout bound.
    task automatic wait_state(input int st, input int stalls, input bit ret, output bit timed_out);
        timed_out = 1'b0;
        for (int k = 0; k < stalls; k++) begin
            if (k == int'(TO) - 1) begin
                push_e(0, st, 0, 0, 1, 0);
                timed_out = 1'b1;
                return;
            end
            push_e(0, st, 0, 0, 0, 0);
        end
        push_e(0, st, 1, 0, 0, ret);
    endtask

    task automatic instr(input string name, input logic [5:0] op, input bit z, input int fw,
                         input int mw, input int exp_len);
        int n0;
        bit t;
        cur_op = op; cur_zero = z; n0 = sched.size();
        wait_state(0, fw, 0, t);
        if (!t) begin
            case (op)
                6'b000000: begin push_e(0, 1, 0, 0, 0, 0); push_e(0, 6, 0, 0, 0, 0);
                                 push_e(0, 7, 0, 0, 0, 1); end
                6'b100011: begin push_e(0, 1, 0, 0, 0, 0); push_e(0, 2, 0, 0, 0, 0);
                                 wait_state(3, mw, 0, t);
                                 if (!t) push_e(0, 4, 0, 0, 0, 1); end
                6'b101011: begin push_e(0, 1, 0, 0, 0, 0); push_e(0, 2, 0, 0, 0, 0);
                                 wait_state(5, mw, 1, t); end
                6'b000100: begin push_e(0, 1, 0, 0, 0, 0); push_e(0, 8, 0, 0, 0, 1); end
                6'b000010: begin push_e(0, 1, 0, 0, 0, 0); push_e(0, 9, 0, 0, 0, 1); end
                6'b001000, 6'b001100, 6'b001101, 6'b001010: begin
                    push_e(0, 1, 0, 0, 0, 0); push_e(0, 10, 0, 0, 0, 0); push_e(0, 11, 0, 0, 0, 1);
                end
                default: push_e(0, 1, 0, 1, 0, 0);
            endcase
        end
        check({"len_", name}, -1, 64'(sched.size() - n0), 64'(exp_len));
    endtask

    initial begin
        int n0;
        bit t;
        logic [15:0] dut_ctl;
        logic [31:0] exp_cc, exp_ic;
        bus.op = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;

        cur_op = 6'd0;
        push_e(1, 0, 0, 0, 0, 0);
        push_e(1, 0, 0, 0, 0, 0);
        instr("lw",       6'b100011, 0, 0, 0,  5);
        instr("beq_t",    6'b000100, 1, 0, 0,  3);
        instr("beq_nt",   6'b000100, 0, 0, 0,  3);
        instr("j",        6'b000010, 0, 0, 0,  3);
        instr("illegal",  6'b111111, 0, 0, 0,  2);
        instr("rtype",    6'b000000, 0, 0, 0,  4);
        instr("addi",     6'b001000, 0, 0, 0,  4);
        instr("andi_st",  6'b001100, 0, 1, 0,  5);
        instr("ori",      6'b001101, 0, 0, 0,  4);
        instr("slti",     6'b001010, 0, 0, 0,  4);
        instr("sw_st3",   6'b101011, 0, 0, 3,  7);
        instr("lw_to",    6'b100011, 0, 0, 10, 7);
        instr("fetch_to", 6'b000000, 0, 10, 0, 4);
        instr("rtype2",   6'b000000, 0, 0, 0,  4);
        // Reset lands on the R_EXEC cycle.
        cur_op = 6'd0; n0 = sched.size();
        wait_state(0, 0, 0, t);
        push_e(0, 1, 0, 0, 0, 0);
        push_e(1, 0, 0, 0, 0, 0);
        check("len_rst_rexec", -1, 64'(sched.size() - n0), 64'd3);
        instr("lw2",      6'b100011, 0, 0, 0,  5);
        instr("sw",       6'b101011, 0, 0, 0,  4);
        push_e(0, 0, 0, 0, 0, 0);

        foreach (sched[i]) begin
            @(negedge clk);
            rst = sched[i].r; bus.op = sched[i].op;
            bus.mem_ready = sched[i].rdy; bus.zero = sched[i].z;
            #2;
            dut_ctl = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
                       bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
                       bus.alu_src_b, bus.alu_op, bus.pc_source};
            exp_cc = PERF ? m_cycle : 32'd0;
            exp_ic = PERF ? m_instr : 32'd0;
            check("state", i, 64'(bus.state), sched[i].r ? 64'd0 : 64'(sched[i].st));
            check("ctrl", i, 64'(dut_ctl), sched[i].r ? 64'd0 : 64'(exp_ctl(sched[i].st,
                                                                             sched[i].rdy)));
            check("pulses", i, 64'({bus.illegal_op, bus.mem_timeout}),
                  sched[i].r ? 64'd0 : 64'({sched[i].ill, sched[i].to}));
            check("counters", i, {bus.cycle_count, bus.instr_count}, {exp_cc, exp_ic});
            if (!sched[i].r && sched[i].st == 8)
                check("branch_pc_update", i,
                      64'(bus.pc_write | (bus.pc_write_cond & bus.zero)), 64'(sched[i].z));
            ill_seen += int'(bus.illegal_op);
            to_seen  += int'(bus.mem_timeout);
            if (sched[i].r) begin
                m_cycle = 32'd0;
                m_instr = 32'd0;
            end else begin
                m_cycle = m_cycle + 32'd1;
                if (sched[i].ret) m_instr = m_instr + 32'd1;
            end
        end

        check("illegal_pulses", -1, 64'(ill_seen), 64'd1);
        check("timeout_pulses", -1, 64'(to_seen), 64'd2);
        check("model_retired", -1, 64'(m_instr), 64'd2);
        check("final_instr_count", -1, 64'(bus.instr_count), PERF ? 64'd2 : 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle sequencer for the MIPS core: a Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback. It drives the shared memory port, IR, PC, register file and ALU selects. Memory access uses a ready handshake, with a bounded wait. It supports R-type, lw, sw, beq, j, addi, andi, ori and slti.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum cycles spent waiting for `mem_ready` in one state (1..65535).
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `op` in 6: IR[31:26], valid from DECODE onward.
- `zero` in 1: ALU zero flag, used by beq.
- `mem_ready` in 1: memory completes the current read or write this cycle.
- `pc_write`, `pc_write_cond` out 1: PC update strobes.
- `i_or_d` out 1: address source select, 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write`, `ir_write` out 1: memory and IR strobes.
- `reg_dst`, `mem_to_reg`, `reg_write` out 1: register file controls.
- `alu_src_a` out 1: ALU A select.
- `alu_src_b` out 2: ALU B select, 00 reg, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- `alu_op` out 2: 00 add, 01 sub, 10 funct decode, 11 immediate decode by `op`.
- `pc_source` out 2: 00 ALU, 01 ALUOut, 10 jump target.
- `state` out 4: current state, for debug.
- `illegal_op`, `mem_timeout` out 1: one-cycle error pulses.
- `cycle_count`, `instr_count` out 32: performance counters.

## Operation
States and encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11. Encodings 12–15 are unreachable and go to FETCH.

Per-state behaviour:
- FETCH:
  - Drives `mem_read`, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00.
  - `ir_write` and `pc_write` are asserted only in the cycle where `mem_ready`=1.
  - Stays in FETCH until `mem_ready`, then goes to DECODE.
- DECODE: drives `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00. Next state by `op`:
  - 000000 → R_EXEC
  - 100011 or 101011 → MEM_ADDR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000, 001100, 001101, 001010 → I_EXEC
  - any other value → FETCH, with `illegal_op` pulsed.
- MEM_ADDR: drives `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: drives `mem_read` and `i_or_d`=1. Waits for `mem_ready`, then goes to MEM_WB.
- MEM_WB: drives `reg_write`, `mem_to_reg`=1, `reg_dst`=0. Goes to FETCH.
- MEM_WRITE: drives `mem_write` and `i_or_d`=1. Waits for `mem_ready`, then goes to FETCH.
- R_EXEC: drives `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Goes to R_WB.
- R_WB: drives `reg_write`, `reg_dst`=1, `mem_to_reg`=0. Goes to FETCH.
- BRANCH: drives `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`, `pc_source`=01. Goes to FETCH.
- JUMP: drives `pc_write`, `pc_source`=10. Goes to FETCH.
- I_EXEC: drives `alu_src_a`=1, `alu_src_b`=10, `alu_op`=11. Goes to I_WB.
- I_WB: drives `reg_write`, `reg_dst`=0, `mem_to_reg`=0. Goes to FETCH.

Outputs not listed for a state are 0.

Wait timer:
- Counts cycles spent in FETCH, MEM_READ or MEM_WRITE with `mem_ready`=0; cleared on any state change.
- When the count reaches `TIMEOUT_CYCLES`, `mem_timeout` pulses and the FSM goes to FETCH.
- A timed-out MEM_WRITE never asserts `reg_write`. A timed-out FETCH re-fetches the same PC, because `pc_write` was never asserted.

## Timing
- Reset:
  - While `rst`=1, every output is 0 (Moore decode gated by `rst`), and the state, wait timer and counters clear.
  - The cycle after `rst` falls is FETCH.
  - Reset mid-instruction aborts it, with no write strobes.
- Latency with `mem_ready` tied to 1: beq/j 3 cycles; R-type, I-type and sw 4 cycles; lw 5 cycles. Each `mem_ready`=0 cycle in a wait state adds one cycle.
- `illegal_op` and `mem_timeout` are high for exactly one cycle, coincident with the transition decision.
- `instr_count` increments on each transition into FETCH from MEM_WB, MEM_WRITE (completed), R_WB, BRANCH, JUMP or I_WB. It does not increment on illegal-op or timeout returns.
- `cycle_count` increments every non-reset cycle. Both counters wrap modulo 2^32.

## Configuration
- `MC_PERF_COUNTERS_EN`:
  - Defined: the counters are implemented as described.
  - Undefined: `cycle_count` and `instr_count` are tied to 0 and no counter flops exist. FSM behaviour is identical.

## Structure
- Package `mips_ctrl_pkg` holds:
  - state enum
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI)
  - ALUOp constants
  - `alu_src_b` and `pc_source` select constants
- Sub-module `mc_op_decode`: combinational `op` → DECODE next state plus illegal flag.

## Test plan
- lw (op=100011), `mem_ready`=1 → states 0,1,2,3,4,0. `reg_write`=1 and `mem_to_reg`=1 only in MEM_WB. `instr_count` +1.
- beq with `zero`=1 → states 0,1,8,0 with `pc_write_cond`=1 and `pc_source`=01 in BRANCH. j → `pc_write`=1 and `pc_source`=10 in JUMP.
- op=111111 → DECODE to FETCH, `illegal_op` high one cycle, `instr_count` unchanged.
- sw with `mem_ready` low for 3 cycles in MEM_WRITE → `mem_write` held 4 cycles, total latency 7.
- `TIMEOUT_CYCLES`=4, `mem_ready` stuck 0 in MEM_READ → `mem_timeout` pulse after 4 cycles, next state FETCH, no `reg_write`.
- `rst` asserted during R_EXEC → all outputs 0 that cycle, FETCH next, `cycle_count`=0 (macro on), constant 0 (macro off).
